// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage load/store unit: memop codes, the
// lane-offset width helper and the pending-load entry layout.
package mem_access_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LH  = 3'b001,
      OP_LHU = 3'b010,
      OP_LB  = 3'b011,
      OP_LBU = 3'b100,
      OP_SB  = 3'b101,
      OP_SH  = 3'b110,
      OP_SW  = 3'b111
   } memop_t;

   // Pending entries are sized for the widest supported bus (64 bit -> 3 offset
   // bits) and for tags up to 8 bits; narrower values are zero-extended.
   localparam int PEND_OFF_W = 3;
   localparam int PEND_TAG_W = 8;

   typedef struct packed {
      memop_t                  memop;
      logic [PEND_OFF_W-1:0]   offset;
      logic [PEND_TAG_W-1:0]   tag;
   } pend_entry_t;

   function automatic int lane_off_width(input int dw);
      return $clog2(dw / 8);
   endfunction

   function automatic logic is_load(input memop_t op);
      return !(op inside {OP_SB, OP_SH, OP_SW});
   endfunction

endpackage

// File: rtl/pending_fifo.sv
// Synchronous FIFO holding in-flight load descriptors. No pop-to-push bypass:
// full is derived from the registered count only.
module pending_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = store[rd_ptr];

   // Entry storage needs no reset; validity is tracked by the count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         store[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap at DEPTH; count tracks occupancy for simultaneous push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: registered issue of byte-lane masked requests,
// misalignment detection, and in-order extraction of returned load data.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no request presented to memory (mem_req_o = 0)
// S_REQ  | request held on mem_* until granted (mem_req_o = 1)
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int DEPTH = 2,
   parameter int TAGW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      req_memop_i,
   input  logic [AW-1:0]   req_addr_i,
   input  logic [31:0]     req_wdata_i,
   input  logic [TAGW-1:0] req_tag_i,
   output logic            stall_o,
   output logic            mem_req_o,
   input  logic            mem_gnt_i,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW/8-1:0] mem_we_o,
   output logic [DW-1:0]   mem_wdata_o,
   input  logic            mem_rvalid_i,
   input  logic [DW-1:0]   mem_rdata_i,
   output logic            rsp_valid_o,
   output logic [31:0]     rsp_data_o,
   output logic [TAGW-1:0] rsp_tag_o,
   output logic            adel_o,
   output logic            ades_o,
   output logic [AW-1:0]   badaddr_o,
   output logic            busy_o
);

   localparam int NB   = DW / 8;
   localparam int OFFW = lane_off_width(DW);

   typedef enum logic {S_IDLE, S_REQ} issue_state_t;

   issue_state_t    state;
   memop_t          op;
   logic [OFFW-1:0] lane;
   logic [OFFW-1:0] lane_inv;
   logic            load_op;
   logic            misaligned;
   logic            accept;
   logic            issue;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [NB-1:0]   we_next;
   logic [DW-1:0]   wdata_next;
   pend_entry_t     push_entry;
   pend_entry_t     head;
   logic [DW-1:0]   rdata_sh;
   logic [31:0]     load_val;
   logic            unused_head;

   assign op       = memop_t'(req_memop_i);
   assign lane     = req_addr_i[OFFW-1:0];
   // Big-endian lanes: offset k lives in we bit NB-1-k, which is ~k.
   assign lane_inv = ~lane;
   assign load_op  = is_load(op);

   assign req_ready_o = ~rst & ((state == S_IDLE) | mem_gnt_i) & ~(load_op & fifo_full);
   assign stall_o     = req_valid_i & ~req_ready_o;
   assign accept      = req_valid_i & req_ready_o;
   assign issue       = accept & ~misaligned;
   assign push        = issue & load_op;
   assign pop         = mem_rvalid_i & ~fifo_empty;
   assign busy_o      = mem_req_o | ~fifo_empty;

   // Alignment rules per access size.
   always_comb begin
      misaligned = 1'b0;
      case (op)
         OP_LH, OP_LHU, OP_SH: misaligned = req_addr_i[0];
         OP_LW, OP_SW:         misaligned = |req_addr_i[1:0];
         default:              misaligned = 1'b0;
      endcase
   end

   // Store byte enables and lane-replicated write data.
   always_comb begin
      we_next    = '0;
      wdata_next = {(DW/32){req_wdata_i}};
      case (op)
         OP_SB: begin
            we_next    = NB'(1) << lane_inv;
            wdata_next = {NB{req_wdata_i[7:0]}};
         end
         OP_SH: begin
            we_next    = NB'(3) << (lane_inv & ~OFFW'(1));
            wdata_next = {(DW/16){req_wdata_i[15:0]}};
         end
         OP_SW: begin
            we_next    = NB'(15) << (lane_inv & ~OFFW'(3));
         end
         default: we_next = '0;
      endcase
   end

   // Issue register: holds the request stable until granted, reloads on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         mem_req_o   <= 1'b0;
         mem_addr_o  <= '0;
         mem_we_o    <= '0;
         mem_wdata_o <= '0;
      end else if (issue) begin
         state       <= S_REQ;
         mem_req_o   <= 1'b1;
         mem_addr_o  <= {req_addr_i[AW-1:OFFW], OFFW'(0)};
         mem_we_o    <= we_next;
         mem_wdata_o <= wdata_next;
      end else if ((state == S_REQ) && mem_gnt_i) begin
         state       <= S_IDLE;
         mem_req_o   <= 1'b0;
      end
   end

   // Misalignment pulses; the faulting address is held until the next fault.
   always_ff @(posedge clk) begin
      if (rst) begin
         adel_o    <= 1'b0;
         ades_o    <= 1'b0;
         badaddr_o <= '0;
      end else begin
         adel_o <= accept & misaligned & load_op;
         ades_o <= accept & misaligned & ~load_op;
         if (accept & misaligned) begin
            badaddr_o <= req_addr_i;
         end
      end
   end

   always_comb begin
      push_entry        = '0;
      push_entry.memop  = op;
      push_entry.offset = PEND_OFF_W'(lane);
      push_entry.tag    = PEND_TAG_W'(req_tag_i);
   end

   pending_fifo #(
      .WIDTH ($bits(pend_entry_t)),
      .DEPTH (DEPTH)
   ) u_pending_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Shift the addressed lane to the top of the bus, then size and extend it.
   always_comb begin
      rdata_sh = mem_rdata_i << {head.offset[OFFW-1:0], 3'b000};
      load_val = rdata_sh[DW-1 -: 32];
      case (head.memop)
         OP_LH:   load_val = {{16{rdata_sh[DW-1]}}, rdata_sh[DW-1 -: 16]};
         OP_LHU:  load_val = {16'h0000, rdata_sh[DW-1 -: 16]};
         OP_LB:   load_val = {{24{rdata_sh[DW-1]}}, rdata_sh[DW-1 -: 8]};
         OP_LBU:  load_val = {24'h000000, rdata_sh[DW-1 -: 8]};
         default: load_val = rdata_sh[DW-1 -: 32];
      endcase
   end

   // Entry fields are sized for the widest configuration.
   assign unused_head = ^{head.offset, head.tag};

   // Load response: one-cycle valid, data and tag held until the next response.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_tag_o   <= '0;
      end else begin
         rsp_valid_o <= pop;
         if (pop) begin
            rsp_data_o <= load_val;
            rsp_tag_o  <= head.tag[TAGW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit and a 64-bit instance share the
// request stimulus; each scenario task checks its own expected values.
module tb_mem_access_unit;

   localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                          LBU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [2:0]  req_memop = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [4:0]  req_tag = '0;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] rdata32 = '0;
   logic [63:0] rdata64 = '0;

   logic        ready32, stall32, mreq32, rspv32, adel32, ades32, busy32;
   logic [31:0] maddr32, mwdata32, rspd32, bad32;
   logic [3:0]  mwe32;
   logic [4:0]  rspt32;

   logic        ready64, stall64, mreq64, rspv64, adel64, ades64, busy64;
   logic [31:0] maddr64, rspd64, bad64;
   logic [63:0] mwdata64;
   logic [7:0]  mwe64;
   logic [4:0]  rspt64;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.DW(32), .AW(32), .DEPTH(2), .TAGW(5)) u_dut32 (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(ready32),
      .req_memop_i(req_memop), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_tag_i(req_tag), .stall_o(stall32), .mem_req_o(mreq32), .mem_gnt_i(mem_gnt),
      .mem_addr_o(maddr32), .mem_we_o(mwe32), .mem_wdata_o(mwdata32),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(rdata32), .rsp_valid_o(rspv32),
      .rsp_data_o(rspd32), .rsp_tag_o(rspt32), .adel_o(adel32), .ades_o(ades32),
      .badaddr_o(bad32), .busy_o(busy32)
   );

   mem_access_unit #(.DW(64), .AW(32), .DEPTH(2), .TAGW(5)) u_dut64 (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(ready64),
      .req_memop_i(req_memop), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_tag_i(req_tag), .stall_o(stall64), .mem_req_o(mreq64), .mem_gnt_i(mem_gnt),
      .mem_addr_o(maddr64), .mem_we_o(mwe64), .mem_wdata_o(mwdata64),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(rdata64), .rsp_valid_o(rspv64),
      .rsp_data_o(rspd64), .rsp_tag_o(rspt64), .adel_o(adel64), .ades_o(ades64),
      .badaddr_o(bad64), .busy_o(busy64)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      tick();
      checks++; if (ready32 !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready32); end
      checks++; if (mreq32 !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mreq32); end
      checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy32); end
      checks++; if (rspv32 !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rspv32); end
      checks++; if (mwe32 !== 4'h0) begin errors++; $display("FAIL rst_we: got %h expected 0", mwe32); end
      checks++; if (bad32 !== 32'h0) begin errors++; $display("FAIL rst_badaddr: got %h expected 0", bad32); end
      rst = 1'b0;
      #1;
      checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", ready32); end
   endtask

   task automatic test_store_sb();
      mem_gnt = 1'b1;
      req_valid = 1'b1; req_memop = SB; req_addr = 32'h103; req_wdata = 32'h000000A5;
      #1;
      checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL sb_ready: got %b expected 1", ready32); end
      tick();
      req_valid = 1'b0;
      checks++; if (mreq32 !== 1'b1) begin errors++; $display("FAIL sb_mem_req: got %b expected 1", mreq32); end
      checks++; if (maddr32 !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h expected 00000100", maddr32); end
      checks++; if (mwe32 !== 4'b0001) begin errors++; $display("FAIL sb_we: got %b expected 0001", mwe32); end
      checks++; if (mwdata32 !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", mwdata32); end
      tick();
      checks++; if (mreq32 !== 1'b0) begin errors++; $display("FAIL sb_release: got %b expected 0", mreq32); end
      checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL sb_busy: got %b expected 0", busy32); end
   endtask

   task automatic test_load_extend();
      logic [2:0]  ops [6]  = '{LH, LHU, LB, LBU, LW, LH};
      logic [31:0] adr [6]  = '{32'h102, 32'h102, 32'h100, 32'h101, 32'h104, 32'h100};
      logic [31:0] rd  [6]  = '{32'h12348765, 32'h12348765, 32'h80112233, 32'h12F45678, 32'hDEADBEEF, 32'h9ABC1234};
      logic [31:0] exp [6]  = '{32'hFFFF8765, 32'h00008765, 32'hFFFFFF80, 32'h000000F4, 32'hDEADBEEF, 32'hFFFF9ABC};
      mem_gnt = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1; req_memop = ops[i]; req_addr = adr[i]; req_tag = 5'(i + 7);
         tick();
         req_valid = 1'b0;
         checks++; if (mwe32 !== 4'h0) begin errors++; $display("FAIL ld%0d_we: got %h expected 0", i, mwe32); end
         tick();
         mem_rvalid = 1'b1; rdata32 = rd[i];
         tick();
         mem_rvalid = 1'b0;
         checks++; if (rspv32 !== 1'b1) begin errors++; $display("FAIL ld%0d_valid: got %b expected 1", i, rspv32); end
         checks++; if (rspd32 !== exp[i]) begin errors++; $display("FAIL ld%0d_data: got %h expected %h", i, rspd32, exp[i]); end
         checks++; if (rspt32 !== 5'(i + 7)) begin errors++; $display("FAIL ld%0d_tag: got %0d expected %0d", i, rspt32, i + 7); end
      end
      tick();
      checks++; if (rspv32 !== 1'b0) begin errors++; $display("FAIL ld_pulse: got %b expected 0", rspv32); end
      checks++; if (rspd32 !== 32'hFFFF9ABC) begin errors++; $display("FAIL ld_hold: got %h expected ffff9abc", rspd32); end
   endtask

   task automatic test_back_to_back();
      mem_gnt = 1'b1;
      req_valid = 1'b1; req_memop = LW; req_addr = 32'h10; req_tag = 5'd1;
      #1;
      checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", ready32); end
      tick();
      checks++; if (maddr32 !== 32'h10) begin errors++; $display("FAIL b2b_addr1: got %h expected 00000010", maddr32); end
      req_addr = 32'h14; req_tag = 5'd2;
      #1;
      checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b expected 1", ready32); end
      tick();
      checks++; if (maddr32 !== 32'h14) begin errors++; $display("FAIL b2b_addr2: got %h expected 00000014", maddr32); end
      req_addr = 32'h18; req_tag = 5'd3;
      #1;
      checks++; if (ready32 !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", ready32); end
      checks++; if (stall32 !== 1'b1) begin errors++; $display("FAIL b2b_full_stall: got %b expected 1", stall32); end
      tick();
      checks++; if (mreq32 !== 1'b0) begin errors++; $display("FAIL b2b_no_issue: got %b expected 0", mreq32); end
      mem_rvalid = 1'b1; rdata32 = 32'h11111111;
      #1;
      checks++; if (ready32 !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass: got %b expected 0", ready32); end
      tick();
      mem_rvalid = 1'b0;
      #1;
      checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL b2b_ready3: got %b expected 1", ready32); end
      checks++; if (stall32 !== 1'b0) begin errors++; $display("FAIL b2b_stall3: got %b expected 0", stall32); end
      checks++; if (rspt32 !== 5'd1) begin errors++; $display("FAIL b2b_tag1: got %0d expected 1", rspt32); end
      checks++; if (rspd32 !== 32'h11111111) begin errors++; $display("FAIL b2b_data1: got %h expected 11111111", rspd32); end
      tick();
      req_valid = 1'b0;
      checks++; if (maddr32 !== 32'h18) begin errors++; $display("FAIL b2b_addr3: got %h expected 00000018", maddr32); end
      mem_rvalid = 1'b1; rdata32 = 32'h22222222;
      tick();
      checks++; if (rspt32 !== 5'd2) begin errors++; $display("FAIL b2b_tag2: got %0d expected 2", rspt32); end
      rdata32 = 32'h33333333;
      tick();
      mem_rvalid = 1'b0;
      checks++; if (rspv32 !== 1'b1) begin errors++; $display("FAIL b2b_valid3: got %b expected 1", rspv32); end
      checks++; if (rspt32 !== 5'd3) begin errors++; $display("FAIL b2b_tag3: got %0d expected 3", rspt32); end
      checks++; if (rspd32 !== 32'h33333333) begin errors++; $display("FAIL b2b_data3: got %h expected 33333333", rspd32); end
      tick();
      checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy32); end
   endtask

   task automatic test_grant_stall();
      mem_gnt = 1'b0;
      req_valid = 1'b1; req_memop = SW; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      #1;
      checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL gs_ready: got %b expected 1", ready32); end
      tick();
      req_memop = SB; req_addr = 32'h30; req_wdata = 32'h0000005A;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (mreq32 !== 1'b1) begin errors++; $display("FAIL gs%0d_req: got %b expected 1", i, mreq32); end
         checks++; if (maddr32 !== 32'h20) begin errors++; $display("FAIL gs%0d_addr: got %h expected 00000020", i, maddr32); end
         checks++; if (mwe32 !== 4'hF) begin errors++; $display("FAIL gs%0d_we: got %h expected f", i, mwe32); end
         checks++; if (mwdata32 !== 32'hCAFEF00D) begin errors++; $display("FAIL gs%0d_wdata: got %h expected cafef00d", i, mwdata32); end
         checks++; if (ready32 !== 1'b0) begin errors++; $display("FAIL gs%0d_ready: got %b expected 0", i, ready32); end
         checks++; if (stall32 !== 1'b1) begin errors++; $display("FAIL gs%0d_stall: got %b expected 1", i, stall32); end
         tick();
      end
      mem_gnt = 1'b1;
      #1;
      checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL gs_gnt_ready: got %b expected 1", ready32); end
      tick();
      req_valid = 1'b0;
      checks++; if (maddr32 !== 32'h30) begin errors++; $display("FAIL gs_reload_addr: got %h expected 00000030", maddr32); end
      checks++; if (mwe32 !== 4'b1000) begin errors++; $display("FAIL gs_reload_we: got %b expected 1000", mwe32); end
      checks++; if (mwdata32 !== 32'h5A5A5A5A) begin errors++; $display("FAIL gs_reload_wdata: got %h expected 5a5a5a5a", mwdata32); end
      tick();
      checks++; if (mreq32 !== 1'b0) begin errors++; $display("FAIL gs_release: got %b expected 0", mreq32); end
   endtask

   task automatic test_misaligned();
      mem_gnt = 1'b1;
      req_valid = 1'b1; req_memop = LW; req_addr = 32'h1002; req_tag = 5'd0;
      tick();
      req_valid = 1'b0;
      checks++; if (mreq32 !== 1'b0) begin errors++; $display("FAIL mis_lw_req: got %b expected 0", mreq32); end
      checks++; if (adel32 !== 1'b1) begin errors++; $display("FAIL mis_lw_adel: got %b expected 1", adel32); end
      checks++; if (ades32 !== 1'b0) begin errors++; $display("FAIL mis_lw_ades: got %b expected 0", ades32); end
      checks++; if (bad32 !== 32'h1002) begin errors++; $display("FAIL mis_lw_bad: got %h expected 00001002", bad32); end
      checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL mis_lw_busy: got %b expected 0", busy32); end
      tick();
      checks++; if (adel32 !== 1'b0) begin errors++; $display("FAIL mis_adel_pulse: got %b expected 0", adel32); end
      checks++; if (bad32 !== 32'h1002) begin errors++; $display("FAIL mis_bad_hold: got %h expected 00001002", bad32); end
      req_valid = 1'b1; req_memop = SH; req_addr = 32'h1001;
      tick();
      req_valid = 1'b0;
      checks++; if (ades32 !== 1'b1) begin errors++; $display("FAIL mis_sh_ades: got %b expected 1", ades32); end
      checks++; if (adel32 !== 1'b0) begin errors++; $display("FAIL mis_sh_adel: got %b expected 0", adel32); end
      checks++; if (bad32 !== 32'h1001) begin errors++; $display("FAIL mis_sh_bad: got %h expected 00001001", bad32); end
      checks++; if (mreq32 !== 1'b0) begin errors++; $display("FAIL mis_sh_req: got %b expected 0", mreq32); end
      req_valid = 1'b1; req_memop = SH; req_addr = 32'h1002; req_wdata = 32'h0000BEEF;
      tick();
      req_valid = 1'b0;
      checks++; if (ades32 !== 1'b0) begin errors++; $display("FAIL al_sh_ades: got %b expected 0", ades32); end
      checks++; if (mreq32 !== 1'b1) begin errors++; $display("FAIL al_sh_req: got %b expected 1", mreq32); end
      checks++; if (mwe32 !== 4'b0011) begin errors++; $display("FAIL al_sh_we: got %b expected 0011", mwe32); end
      checks++; if (mwdata32 !== 32'hBEEFBEEF) begin errors++; $display("FAIL al_sh_wdata: got %h expected beefbeef", mwdata32); end
      tick();
   endtask

   task automatic test_dw64();
      do_reset();
      mem_gnt = 1'b1;
      req_valid = 1'b1; req_memop = LB; req_addr = 32'h5; req_tag = 5'd9;
      tick();
      req_valid = 1'b0;
      checks++; if (mreq64 !== 1'b1) begin errors++; $display("FAIL d64_lb_req: got %b expected 1", mreq64); end
      checks++; if (maddr64 !== 32'h0) begin errors++; $display("FAIL d64_lb_addr: got %h expected 0", maddr64); end
      tick();
      mem_rvalid = 1'b1; rdata64 = 64'h0011223344556677;
      tick();
      mem_rvalid = 1'b0;
      checks++; if (rspv64 !== 1'b1) begin errors++; $display("FAIL d64_lb_valid: got %b expected 1", rspv64); end
      checks++; if (rspd64 !== 32'h00000055) begin errors++; $display("FAIL d64_lb_data: got %h expected 00000055", rspd64); end
      checks++; if (rspt64 !== 5'd9) begin errors++; $display("FAIL d64_lb_tag: got %0d expected 9", rspt64); end
      req_valid = 1'b1; req_memop = LHU; req_addr = 32'h2; req_tag = 5'd10;
      tick();
      req_valid = 1'b0;
      tick();
      mem_rvalid = 1'b1; rdata64 = 64'h0011ABCD44556677;
      tick();
      mem_rvalid = 1'b0;
      checks++; if (rspd64 !== 32'h0000ABCD) begin errors++; $display("FAIL d64_lhu_data: got %h expected 0000abcd", rspd64); end
      req_valid = 1'b1; req_memop = SW; req_addr = 32'h4; req_wdata = 32'h89ABCDEF;
      tick();
      checks++; if (mwe64 !== 8'h0F) begin errors++; $display("FAIL d64_sw_hi_we: got %h expected 0f", mwe64); end
      checks++; if (mwdata64 !== 64'h89ABCDEF89ABCDEF) begin errors++; $display("FAIL d64_sw_wdata: got %h expected 89abcdef89abcdef", mwdata64); end
      req_addr = 32'h8;
      tick();
      req_valid = 1'b0;
      checks++; if (mwe64 !== 8'hF0) begin errors++; $display("FAIL d64_sw_lo_we: got %h expected f0", mwe64); end
      checks++; if (maddr64 !== 32'h8) begin errors++; $display("FAIL d64_sw_addr: got %h expected 00000008", maddr64); end
      tick();
      req_valid = 1'b1; req_memop = LW; req_addr = 32'h10; req_tag = 5'd4;
      tick();
      req_valid = 1'b0;
      tick();
      checks++; if (busy64 !== 1'b1) begin errors++; $display("FAIL d64_outstanding: got %b expected 1", busy64); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL d64_rst_busy: got %b expected 0", busy64); end
      mem_rvalid = 1'b1; rdata64 = 64'hFFFFFFFFFFFFFFFF;
      tick();
      mem_rvalid = 1'b0;
      checks++; if (rspv64 !== 1'b0) begin errors++; $display("FAIL d64_stale_rsp: got %b expected 0", rspv64); end
      checks++; if (rspv32 !== 1'b0) begin errors++; $display("FAIL d32_stale_rsp: got %b expected 0", rspv32); end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_store_sb();
      test_load_extend();
      test_back_to_back();
      test_grant_stall();
      test_misaligned();
      test_dw64();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
